// File: rtl/dynamic_input_route_pkg.sv
// rtl/dynamic_input_route_pkg.sv - shared network widths, header field offsets, route and FSM encodings
//
// Purpose: one place for flit geometry and the encodings used by the router
// input port. The width macros are the network-wide knobs. The localparams
// below derive the header field positions from them, starting at the flit MSB.
// Ports: none (package).

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif
`ifndef FBITS_WIDTH
`define FBITS_WIDTH 4
`endif

package dynamic_input_route_pkg;

    localparam int DATA_W  = `DATA_WIDTH;
    localparam int CHIP_W  = `CHIP_ID_WIDTH;
    localparam int XY_W    = `XY_WIDTH;
    localparam int LEN_W   = `PAYLOAD_LEN;
    localparam int FBITS_W = `FBITS_WIDTH;

    // Header layout, packed downward from the MSB: chip, x, y, fbits, len.
    localparam int CHIP_HI = DATA_W - 1;
    localparam int CHIP_LO = DATA_W - CHIP_W;
    localparam int X_HI    = CHIP_LO - 1;
    localparam int X_LO    = CHIP_LO - XY_W;
    localparam int Y_HI    = X_LO - 1;
    localparam int Y_LO    = X_LO - XY_W;
    localparam int FB_HI   = Y_LO - 1;
    localparam int FB_LO   = Y_LO - FBITS_W;
    localparam int LEN_HI  = FB_LO - 1;
    localparam int LEN_LO  = FB_LO - LEN_W;

    typedef enum logic [2:0] {
        ROUTE_N = 3'd0,
        ROUTE_E = 3'd1,
        ROUTE_S = 3'd2,
        ROUTE_W = 3'd3,
        ROUTE_P = 3'd4
    } route_e;

    typedef enum logic {
        ST_HEADER = 1'b0,
        ST_BODY   = 1'b1
    } state_e;

    // Dimension-order (X then Y) routing. An off-chip destination is steered
    // toward (0,0). Once there, it leaves on W, which is the off-chip port.
    function automatic route_e compute_route(
        input logic [CHIP_W-1:0] dest_chip,
        input logic [XY_W-1:0]   dest_x,
        input logic [XY_W-1:0]   dest_y,
        input logic [CHIP_W-1:0] my_chip,
        input logic [XY_W-1:0]   my_x,
        input logic [XY_W-1:0]   my_y
    );
        logic            off_chip;
        logic [XY_W-1:0] tx;
        logic [XY_W-1:0] ty;
        off_chip = (dest_chip != my_chip);
        tx = off_chip ? '0 : dest_x;
        ty = off_chip ? '0 : dest_y;
        if (tx > my_x)      compute_route = ROUTE_E;
        else if (tx < my_x) compute_route = ROUTE_W;
        else if (ty > my_y) compute_route = ROUTE_S;
        else if (ty < my_y) compute_route = ROUTE_N;
        else if (off_chip)  compute_route = ROUTE_W;
        else                compute_route = ROUTE_P;
    endfunction

endpackage

// File: rtl/dynamic_input_buffer.sv
// rtl/dynamic_input_buffer.sv - circular flit FIFO for one router input port
//
// Purpose: BUF_DEPTH x DATA_W storage. The read and write pointers carry one
// extra wrap bit, so full and empty are told apart without a separate counter.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (pointers only)
//   push, wdata    - write wdata at the tail; caller guarantees !full or same-cycle pop
//   pop            - advance the head; caller guarantees !empty
//   rdata          - head entry (combinational read)
//   empty, full    - occupancy flags

import dynamic_input_route_pkg::*;

module dynamic_input_buffer #(
    parameter int BUF_DEPTH = 4,
    parameter int BUF_AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);

    localparam logic [BUF_AW:0] PTR_ONE = {{BUF_AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [BUF_AW:0]   wr_ptr;
    logic [BUF_AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; a reset empties the FIFO by pointer alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[BUF_AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[BUF_AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[BUF_AW] != rd_ptr[BUF_AW]) &&
                   (wr_ptr[BUF_AW-1:0] == rd_ptr[BUF_AW-1:0]);

endmodule

// File: rtl/dynamic_input_route_top.sv
// rtl/dynamic_input_route_top.sv - dynamic-network router input port: credit receive, FIFO, route decode
//
// Purpose: buffers incoming flits and decodes the packet header into a one-hot
// request toward N/E/S/W/P. The route is held for the packet's body. The head
// flit pops on any output's thanks, and each pop returns one yummy credit.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   my_loc_x_in/my_loc_y_in/my_chip_id_in - this tile's coordinates
//   data_in, valid_in                  - upstream flit link
//   yummy_out                          - one credit per popped flit, one cycle after the pop
//   data_out, valid_out                - head flit and FIFO non-empty
//   route_req_{n,e,s,w,p}_out          - one-hot request for the current packet
//   tail_out                           - head is its packet's last flit
//   thanks_{n,e,s,w,p}_in              - head consumed by that output
//   overflow_err_out                   - sticky: flit lost to a full FIFO

import dynamic_input_route_pkg::*;

module dynamic_input_route_top #(
    parameter int BUF_DEPTH = 4,
    parameter int BUF_AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XY_W-1:0]   my_loc_x_in,
    input  logic [XY_W-1:0]   my_loc_y_in,
    input  logic [CHIP_W-1:0] my_chip_id_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              yummy_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              route_req_n_out,
    output logic              route_req_e_out,
    output logic              route_req_s_out,
    output logic              route_req_w_out,
    output logic              route_req_p_out,
    output logic              tail_out,
    input  logic              thanks_n_in,
    input  logic              thanks_e_in,
    input  logic              thanks_s_in,
    input  logic              thanks_w_in,
    input  logic              thanks_p_in,
    output logic              overflow_err_out
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [4:0]        thanks_vec;

    state_e            state, state_next;
    logic [LEN_W-1:0]  count, count_next;
    route_e            route_lat, route_lat_next;
    route_e            hdr_route;
    route_e            active_route;
    logic [LEN_W-1:0]  hdr_len;

    assign thanks_vec = {thanks_n_in, thanks_e_in, thanks_s_in, thanks_w_in, thanks_p_in};
    assign valid_out  = ~empty;
    assign pop        = (|thanks_vec) & valid_out;
    // A full FIFO can still accept a flit when the head leaves in the same cycle.
    assign push       = valid_in & (~full | pop);

    dynamic_input_buffer #(
        .BUF_DEPTH (BUF_DEPTH),
        .BUF_AW    (BUF_AW)
    ) u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (data_in),
        .pop   (pop),
        .rdata (data_out),
        .empty (empty),
        .full  (full)
    );

    assign hdr_len   = data_out[LEN_HI:LEN_LO];
    assign hdr_route = compute_route(data_out[CHIP_HI:CHIP_LO], data_out[X_HI:X_LO],
                                     data_out[Y_HI:Y_LO], my_chip_id_in,
                                     my_loc_x_in, my_loc_y_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_HEADER;
            count            <= '0;
            route_lat        <= ROUTE_P;
            yummy_out        <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            route_lat <= route_lat_next;
            yummy_out <= pop;
            if (valid_in & full & ~pop) overflow_err_out <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        route_lat_next = route_lat;
        case (state)
            ST_HEADER: begin
                if (pop && hdr_len != '0) begin
                    state_next     = ST_BODY;
                    count_next     = hdr_len;
                    route_lat_next = hdr_route;
                end
            end
            ST_BODY: begin
                if (pop) begin
                    count_next = count - LEN_ONE;
                    if (count == LEN_ONE) state_next = ST_HEADER;
                end
            end
            default: state_next = ST_HEADER;
        endcase
    end

    // Body flits carry payload, not a header, so they follow the latched route.
    always_comb begin
        active_route    = (state == ST_HEADER) ? hdr_route : route_lat;
        route_req_n_out = valid_out & (active_route == ROUTE_N);
        route_req_e_out = valid_out & (active_route == ROUTE_E);
        route_req_s_out = valid_out & (active_route == ROUTE_S);
        route_req_w_out = valid_out & (active_route == ROUTE_W);
        route_req_p_out = valid_out & (active_route == ROUTE_P);
        tail_out        = valid_out & (((state == ST_HEADER) && (hdr_len == '0)) ||
                                       ((state == ST_BODY) && (count == LEN_ONE)));
    end

    // Output arbitration must grant at most one port per flit.
    always_ff @(posedge clk) begin
        if (!reset && valid_out) begin
            assert ($onehot0(thanks_vec));
        end
    end

endmodule

// File: tb/tb_dynamic_input_route_top.sv
// tb/tb_dynamic_input_route_top.sv - directed self-checking bench for dynamic_input_route_top

module tb_dynamic_input_route_top;

    localparam logic [4:0] R_N = 5'b10000;
    localparam logic [4:0] R_E = 5'b01000;
    localparam logic [4:0] R_S = 5'b00100;
    localparam logic [4:0] R_W = 5'b00010;
    localparam logic [4:0] R_P = 5'b00001;
    localparam logic [13:0] CHIP  = 14'h0005;
    localparam logic [13:0] OTHER = 14'h0123;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  my_x, my_y;
    logic [13:0] my_chip;
    logic [63:0] data_in;
    logic        valid_in;
    logic [4:0]  thk;
    logic        yummy, valid_out, tail, ovf;
    logic        rq_n, rq_e, rq_s, rq_w, rq_p;
    logic [63:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    // {valid, req n/e/s/w/p, tail, yummy, overflow}
    wire [8:0] obs = {valid_out, rq_n, rq_e, rq_s, rq_w, rq_p, tail, yummy, ovf};

    always #5 clk = ~clk;

    dynamic_input_route_top #(.BUF_DEPTH(4), .BUF_AW(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .my_loc_x_in      (my_x),
        .my_loc_y_in      (my_y),
        .my_chip_id_in    (my_chip),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .yummy_out        (yummy),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .route_req_n_out  (rq_n),
        .route_req_e_out  (rq_e),
        .route_req_s_out  (rq_s),
        .route_req_w_out  (rq_w),
        .route_req_p_out  (rq_p),
        .tail_out         (tail),
        .thanks_n_in      (thk[4]),
        .thanks_e_in      (thk[3]),
        .thanks_s_in      (thk[2]),
        .thanks_w_in      (thk[1]),
        .thanks_p_in      (thk[0]),
        .overflow_err_out (ovf)
    );

    function automatic logic [63:0] hdr(input logic [13:0] chip, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] len);
        hdr = {chip, x, y, 4'h0, len, 22'h2A5A5};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; thk = 5'b0; data_in = '0;
        my_x = 8'd2; my_y = 8'd2; my_chip = CHIP;
        step(); step();
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [63:0] h;
        h = hdr(CHIP, 8'd2, 8'd2, 8'd0);
        my_x = 8'd2; my_y = 8'd2;
        data_in = h; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n_checks++;
        if (obs !== {1'b1, R_P, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_head: got %b expected %b", obs, {1'b1, R_P, 3'b100});
        end
        n_checks++;
        if (data_out !== h) begin
            n_fail++; $display("FAIL single_data: got %h expected %h", data_out, h);
        end
        thk = R_P;
        step();
        thk = 5'b0;
        n_checks++;
        if (obs !== 9'b0_00000_010) begin
            n_fail++; $display("FAIL single_pop: got %b expected %b", obs, 9'b0_00000_010);
        end
        step();
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL single_yummy_once: got %b expected %b", obs, 9'b0);
        end
    endtask

    task automatic test_stream();
        logic [63:0] f [4];
        logic [8:0]  exp;
        my_x = 8'd2; my_y = 8'd2;
        f[0] = hdr(CHIP, 8'd5, 8'd1, 8'd3);
        // Body words that would decode as W/len 0 if the port wrongly decoded them.
        for (int i = 1; i < 4; i++) f[i] = hdr(CHIP, 8'd0, 8'd0, 8'd0) ^ 64'(i);
        for (int i = 0; i < 4; i++) begin
            data_in = f[i]; valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, R_E, (i == 3), (i > 0), 1'b0};
            n_checks++;
            if (obs !== exp || data_out !== f[i]) begin
                n_fail++; $display("FAIL stream_flit%0d: got %b/%h expected %b/%h", i, obs, data_out, exp, f[i]);
            end
            thk = R_E;
            step();
            thk = 5'b0;
        end
        n_checks++;
        if (obs !== 9'b0_00000_010) begin
            n_fail++; $display("FAIL stream_last_yummy: got %b expected %b", obs, 9'b0_00000_010);
        end
        step();
    endtask

    task automatic test_route();
        logic [7:0]  t_mx [6]  = '{8'd2, 8'd2, 8'd0, 8'd2, 8'd2, 8'd0};
        logic [7:0]  t_my [6]  = '{8'd3, 8'd3, 8'd0, 8'd3, 8'd3, 8'd3};
        logic [13:0] t_ch [6]  = '{CHIP, CHIP, OTHER, CHIP, OTHER, OTHER};
        logic [7:0]  t_dx [6]  = '{8'd2, 8'd0, 8'd3, 8'd2, 8'd2, 8'd0};
        logic [7:0]  t_dy [6]  = '{8'd0, 8'd3, 8'd3, 8'd5, 8'd3, 8'd3};
        logic [4:0]  t_ex [6]  = '{R_N, R_W, R_W, R_S, R_W, R_N};
        for (int i = 0; i < 6; i++) begin
            my_x = t_mx[i]; my_y = t_my[i];
            data_in = hdr(t_ch[i], t_dx[i], t_dy[i], 8'd0); valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            n_checks++;
            if (obs[7:3] !== t_ex[i] || valid_out !== 1'b1) begin
                n_fail++; $display("FAIL route_%0d: got req %b valid %b expected req %b valid 1", i, obs[7:3], valid_out, t_ex[i]);
            end
            thk = t_ex[i];
            step();
            thk = 5'b0;
            step();
        end
    endtask

    task automatic test_overflow();
        logic [63:0] f [6];
        my_x = 8'd2; my_y = 8'd2;
        for (int k = 0; k < 6; k++) f[k] = hdr(CHIP, 8'd2, 8'd2, 8'd0) | 64'(k + 16);
        for (int k = 0; k < 4; k++) begin
            data_in = f[k]; valid_in = 1'b1;
            step();
        end
        n_checks++;
        if (obs !== {1'b1, R_P, 3'b100}) begin
            n_fail++; $display("FAIL ovf_full: got %b expected %b", obs, {1'b1, R_P, 3'b100});
        end
        data_in = f[4]; thk = R_P;
        step();
        thk = 5'b0;
        n_checks++;
        if (obs !== {1'b1, R_P, 3'b110} || data_out !== f[1]) begin
            n_fail++; $display("FAIL ovf_push_pop: got %b/%h expected %b/%h", obs, data_out, {1'b1, R_P, 3'b110}, f[1]);
        end
        data_in = f[5];
        step();
        valid_in = 1'b0;
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf);
        end
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== f[k]) begin
                n_fail++; $display("FAIL ovf_drain%0d: got %b/%h expected 1/%h", k, valid_out, data_out, f[k]);
            end
            thk = R_P;
            step();
            thk = 5'b0;
        end
        n_checks++;
        if (valid_out !== 1'b0 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky_empty: got valid %b ovf %b expected 0 1", valid_out, ovf);
        end
        step();
    endtask

    task automatic test_reset_mid();
        my_x = 8'd2; my_y = 8'd2;
        data_in = hdr(CHIP, 8'd2, 8'd2, 8'd3); valid_in = 1'b1; step();
        data_in = 64'h1111; step();
        data_in = 64'h2222; step();
        valid_in = 1'b0;
        thk = R_P;
        step(); step();
        n_checks++;
        if (obs !== {1'b1, R_P, 3'b011}) begin
            n_fail++; $display("FAIL mid_body_cnt2: got %b expected %b", obs, {1'b1, R_P, 3'b011});
        end
        reset = 1'b1;
        step();
        reset = 1'b0; thk = 5'b0;
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL mid_reset: got %b expected %b", obs, 9'b0);
        end
        data_in = hdr(CHIP, 8'd2, 8'd2, 8'd0); valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n_checks++;
        if (obs !== {1'b1, R_P, 3'b100}) begin
            n_fail++; $display("FAIL mid_header_after: got %b expected %b", obs, {1'b1, R_P, 3'b100});
        end
        thk = R_P; step(); thk = 5'b0; step();
    endtask

    task automatic test_empty_thanks();
        logic [63:0] h;
        h = hdr(CHIP, 8'd2, 8'd2, 8'd0) | 64'h7;
        thk = R_W;
        step();
        thk = 5'b0;
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL empty_thanks: got %b expected %b", obs, 9'b0);
        end
        data_in = h; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n_checks++;
        if (obs !== {1'b1, R_P, 3'b100} || data_out !== h) begin
            n_fail++; $display("FAIL empty_ptrs: got %b/%h expected %b/%h", obs, data_out, {1'b1, R_P, 3'b100}, h);
        end
        thk = R_P;
        step();
        thk = 5'b0;
        n_checks++;
        if (obs !== 9'b0_00000_010) begin
            n_fail++; $display("FAIL empty_final: got %b expected %b", obs, 9'b0_00000_010);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_route();
        test_overflow();
        test_reset_mid();
        test_empty_thanks();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dynamic_input_route_top.md
# dynamic_input_route_top

Receive side of one dynamic-network router port. Accepts flits on the valid/yummy credit link from the upstream router's output port and buffers them in a small FIFO. Decodes each packet header into a one-hot route request toward N/E/S/W/P (dimension-order, X then Y). Pops flits on the granting output's thanks and returns one yummy credit per pop. One instance sits on each router input, feeding the five output ports' route_req/tail/valid/data inputs.

## Interface
Parameters:
- BUF_DEPTH, 4 — FIFO entries; power of two ≥2; equals the upstream credit count.
- BUF_AW, 2 — log2(BUF_DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- my_loc_x_in  in  `XY_WIDTH  this tile X.
- my_loc_y_in  in  `XY_WIDTH  this tile Y.
- my_chip_id_in  in  `CHIP_ID_WIDTH  this chip ID.
- data_in  in  `DATA_WIDTH  incoming flit.
- valid_in  in  1  flit present on data_in this cycle.
- yummy_out  out  1  one credit returned upstream.
- data_out  out  `DATA_WIDTH  head-of-FIFO flit.
- valid_out  out  1  FIFO non-empty.
- route_req_n_out / _e_out / _s_out / _w_out / _p_out  out  1 each  one-hot request for the current packet.
- tail_out  out  1  head flit is the last flit of its packet.
- thanks_n_in / _e_in / _s_in / _w_in / _p_in  in  1 each  head flit consumed by that output.
- overflow_err_out  out  1  sticky: flit arrived with FIFO full and no pop.

## Operation
- Header fields at the head flit: chip ID [63:50], dest X [49:42], dest Y [41:34], fbits [33:30], payload length [29:22]. Positions derive from the `DATA_WIDTH/`CHIP_ID_WIDTH/`XY_WIDTH/`PAYLOAD_LEN macros.
- Route computation on the header:
  - Chip mismatch: treat the destination as X=0, Y=0; at (0,0), route W.
  - Otherwise X first: destX>myX → E; destX<myX → W.
  - Then Y: destY>myY → S; destY<myY → N.
  - Both match → P.
- FSM states:
  - HEADER: head is a header. route_req is combinational from the head; asserted only when valid_out=1.
  - BODY: route latched at the header pop, held with valid_out gating. Body flits are never decoded.
- Transitions:
  - HEADER→BODY: on a header pop with len≠0; count←len.
  - BODY: each pop decrements count. A pop at count==1 → HEADER.
  - A header with len==0 stays in HEADER.
- tail_out = valid_out & ((HEADER & len==0) | (BODY & count==1)).
- Pop = OR of the five thanks inputs. Thanks while valid_out=0 is ignored. More than one thanks in a cycle is a protocol error (asserted in sim); the flit pops once.
- Push when valid_in=1 and the FIFO is not full, or is full and popping this cycle.
- Push while full without a pop: flit dropped, overflow_err_out set until reset.
- Count width `PAYLOAD_LEN; no wrap is possible since count≥1 in BODY.

## Timing
- Reset: FIFO empty, valid_out=0, all route_req=0, tail_out=0, yummy_out=0, overflow_err_out=0, FSM=HEADER, count=0.
- Reset mid-packet discards all buffered flits and any in-flight credit state; upstream resets in the same cycle.
- valid_in at edge t → valid_out=1 from t+1. No same-cycle bypass.
- Pop at edge t → next head visible from t+1; yummy_out=1 for exactly the cycle t+1. One yummy pulse per pop; back-to-back pops give a continuous yummy.
- Simultaneous push and pop: both take effect; occupancy unchanged.
- Sustained throughput: one flit per cycle.

## Structure
- The shared network package holds:
  - width macros and header field offsets;
  - route encoding (N,E,S,W,P);
  - FSM state encoding.
- Sub-module `dynamic_input_buffer`: BUF_DEPTH×`DATA_WIDTH circular FIFO with read/write pointers of BUF_AW+1 bits; full/empty from the MSB compare.
- Route decode, FSM and yummy register stay in the top.

## Test plan
- Reset, then a single header at me=(2,2), dest (2,2), same chip, len 0 → route_req_p=1 and tail_out=1 at t+1; thanks_p at t+1 → valid_out=0 and yummy_out=1 at t+2.
- Header dest (5,1), len 3, plus 3 body flits streamed → route_req_e held across all 4 flits; tail_out only on the 4th; 4 yummy pulses.
- Dest (2,0) from (2,3), then dest (0,3) → N, then W; foreign chip ID at (0,0) → W.
- Fill to BUF_DEPTH=4 with no thanks, then push+thanks in the same cycle → occupancy stays 4, no overflow_err_out; a 5th push without pop → overflow_err_out=1, flit dropped.
- Reset asserted in BODY with count=2 → next cycle valid_out=0, FSM=HEADER, no yummy.
- Thanks_w while empty → no pop, no yummy, pointers unchanged.
